spi_slave_bytes: RTL and testbench
==================================

Name: spi_slave_bytes

Overview:
SPI responder for up to 4-byte transactions. It is the far end of the existing multi-byte SPI master wrapper and is used on boards that act as an SPI target. SCK, CS and MOSI are oversampled in the system clock domain, received bytes are assembled into a 32-bit word, and a preloaded 32-bit response word is shifted out on MISO. Byte order is LSB-byte first, bit order MSB first within each byte, matching the master.

Parameters:
SYNC_STAGES, 2, synchroniser depth for cs/sck/mosi (minimum 2).
MISO_IDLE, 1'b0, MISO value while not selected or after the 4th byte.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
mode  in  2  [1]=CPOL, [0]=CPHA; sampled at synchronised CS fall
txdata  in  32  response word; sampled at synchronised CS fall; byte0 = [7:0]
rx_byte  out  8  most recent received byte
rx_byte_valid  out  1  one-clk pulse per completed byte
rx_byte_idx  out  3  index of rx_byte within the frame (0..7, saturates at 7)
readdata  out  32  assembled frame; byte k in [8k+7:8k]; unfilled bytes are 0
byte_cnt  out  3  complete bytes in last frame (saturates at 7)
frame_done  out  1  one-clk pulse; readdata/byte_cnt/frame_err valid
frame_err  out  1  last frame had a partial byte or more than 4 bytes
busy  out  1  high while the synchronised CS is low
cs  in  1  chip select, active low, asynchronous to clk
sck  in  1  SPI clock, asynchronous to clk
mosi  in  1  master out
miso  out  1  slave out
miso_oe  out  1  high while selected (tri-state enable for the pad)

Behaviour:
- Reset values: all outputs 0, except miso = MISO_IDLE. FSM = IDLE; bit/byte counters = 0.
- Synchronisation: cs, sck and mosi each pass through SYNC_STAGES flops. Edges are detected against one further registered copy.
- Clock ratio: the SCK half-period must be at least 4 clk periods. Nothing is guaranteed below that.
- Leading edge = SCK rise when CPOL=0, SCK fall when CPOL=1.
- CPHA=0: sample on the leading edge, shift on the trailing edge. Bit 7 of byte0 drives MISO in the clk after the CS fall is detected.
- CPHA=1: shift on the leading edge (this also drives the first bit), sample on the trailing edge.
- FSM states:
  - IDLE: on CS fall, latch mode and txdata, clear the shift register and counters, set miso_oe, go to SHIFT.
  - SHIFT: count sampled bits 0..7. On the 8th sample, pulse rx_byte_valid one clk later with rx_byte and rx_byte_idx. For bytes 0..3, write rx_byte into the readdata shadow lane. Increment byte_cnt (saturating at 7) and reset the bit count. On CS rise, go to DONE.
  - DONE: for one clk, copy the shadow to readdata, update byte_cnt and frame_err, pulse frame_done, clear miso_oe, drive miso = MISO_IDLE. Then return to IDLE.
- TX: byte k = txdata[8k+7:8k], MSB first. After the 32nd bit, miso = MISO_IDLE for the rest of the frame.
- Frame errors:
  - A partial byte (1-7 bits) at CS rise is discarded: no rx_byte_valid, not counted, frame_err = 1.
  - More than 4 bytes: bytes beyond the 4th still pulse rx_byte_valid but are not stored; frame_err = 1.
- Zero-bit frame (CS low then high with no SCK edges): frame_done pulses with byte_cnt = 0, readdata = 0, frame_err = 0.
- Edge priority: an SCK edge detected in the same clk as a CS rise is ignored. CS rise always takes priority.
- Mid-frame changes: mode and txdata changes during a frame have no effect; the values latched at CS fall hold until the next frame.
- Reset mid-frame: all state clears immediately. A frame still in progress after reset is ignored until CS is seen high and then falls again.
- Latencies:
  - CS fall to miso_oe: SYNC_STAGES+1 clk.
  - Last sampling edge at the pin to rx_byte_valid: SYNC_STAGES+2 clk.
  - CS rise to frame_done: SYNC_STAGES+2 clk.

Test Plan:
1. Mode 0, master writes 0xA5C30F81 with byte_num=3, txdata=0x12345678 -> rx_byte sequence 0x81,0x0F,0xC3,0xA5; readdata=0xA5C30F81; byte_cnt=4; frame_err=0; master reads 0x12345678.
2. Modes 1, 2 and 3, 2-byte frame with writedata 0x00003C96, txdata=0x0000BEEF -> readdata=0x00003C96, byte_cnt=2, master reads 0x0000BEEF in every mode.
3. CS held low across two 1-byte master triggers, then released -> one frame_done only; byte_cnt=2; rx_byte_idx pulses 0 then 1.
4. 12 SCK cycles, then CS high -> byte_cnt=1, readdata[31:8]=0, frame_err=1, exactly one rx_byte_valid.
5. 5-byte frame 0x11,0x22,0x33,0x44,0x55 -> readdata=0x44332211, byte_cnt=5, frame_err=1, 5 rx_byte_valid pulses; MISO = MISO_IDLE during byte 4.
6. rst asserted after 10 bits, then released while CS is still low; next full 1-byte frame 0x5A -> no frame_done for the aborted frame; next frame gives readdata=0x0000005A.

Source files
------------

// File: rtl/spi_slave_bytes_if.sv
// spi_slave_bytes_if: host-side and SPI pin bundle for the byte-oriented SPI responder.
interface spi_slave_bytes_if;
    logic [1:0]  mode;
    logic [31:0] txdata;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [2:0]  rx_byte_idx;
    logic [31:0] readdata;
    logic [2:0]  byte_cnt;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        miso_oe;

    modport slave (
        input  mode, txdata, cs, sck, mosi,
        output rx_byte, rx_byte_valid, rx_byte_idx, readdata, byte_cnt,
               frame_done, frame_err, busy, miso, miso_oe
    );

    modport master (
        output mode, txdata, cs, sck, mosi,
        input  rx_byte, rx_byte_valid, rx_byte_idx, readdata, byte_cnt,
               frame_done, frame_err, busy, miso, miso_oe
    );
endinterface

// File: rtl/spi_slave_bytes.sv
// spi_slave_bytes: oversampled SPI responder for up to 4-byte frames, LSB byte first, MSB bit first.
module spi_slave_bytes #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input logic             clk,
    input logic             rst,
    spi_slave_bytes_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 r_state, w_state_n;
    logic [SYNC_STAGES-1:0] r_cs_s, r_sck_s, r_mosi_s;
    logic                   r_cs_d, r_sck_d;
    logic                   w_cs, w_sck, w_mosi;
    logic                   w_cs_fall, w_cs_rise, w_rise, w_fall, w_lead, w_trail;
    logic                   w_start, w_smp, w_shf, w_fin;
    logic [1:0]             r_mode;
    logic [31:0]            r_tx, r_shadow, r_readdata;
    logic [7:0]             r_shift, r_rx_byte;
    logic [2:0]             r_bit_cnt, r_cnt, r_rx_idx, r_byte_cnt;
    logic [5:0]             r_tx_idx;
    logic                   r_pend, r_rx_valid, r_frame_done, r_frame_err, r_miso, r_miso_oe;

    assign w_cs      = r_cs_s[SYNC_STAGES-1];
    assign w_sck     = r_sck_s[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
    assign w_cs_fall = ~w_cs & r_cs_d;
    assign w_cs_rise = w_cs & ~r_cs_d;
    assign w_rise    = w_sck & ~r_sck_d;
    assign w_fall    = ~w_sck & r_sck_d;
    assign w_lead    = r_mode[1] ? w_fall : w_rise;
    assign w_trail   = r_mode[1] ? w_rise : w_fall;

    // Synchronisers reset to 0 so a CS already low after reset never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_s   <= '0;
            r_sck_s  <= '0;
            r_mosi_s <= '0;
            r_cs_d   <= 1'b0;
            r_sck_d  <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], bus.cs};
            r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], bus.sck};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], bus.mosi};
            r_cs_d   <= w_cs;
            r_sck_d  <= w_sck;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    // CS rise masks any SCK edge seen in the same clk.
    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_smp     = 1'b0;
        w_shf     = 1'b0;
        w_fin     = 1'b0;
        case (r_state)
            IDLE: begin
                w_start   = w_cs_fall;
                w_state_n = w_cs_fall ? SHIFT : IDLE;
            end
            SHIFT: begin
                w_smp     = ~w_cs_rise & (r_mode[0] ? w_trail : w_lead);
                w_shf     = ~w_cs_rise & (r_mode[0] ? w_lead : w_trail);
                w_state_n = w_cs_rise ? DONE : SHIFT;
            end
            DONE: begin
                w_fin     = 1'b1;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= '0;
            r_tx         <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pend       <= 1'b0;
            r_shadow     <= '0;
            r_cnt        <= '0;
            r_tx_idx     <= '0;
            r_miso       <= MISO_IDLE;
            r_miso_oe    <= 1'b0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_idx     <= '0;
            r_readdata   <= '0;
            r_byte_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid   <= r_pend;
            r_frame_done <= w_fin;
            r_pend       <= w_smp && r_bit_cnt == 3'd7;
            if (w_start) begin
                r_mode    <= bus.mode;
                r_tx      <= bus.txdata;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_cnt     <= '0;
                r_shadow  <= '0;
                r_miso_oe <= 1'b1;
                r_miso    <= bus.mode[0] ? MISO_IDLE : bus.txdata[7];
                r_tx_idx  <= bus.mode[0] ? 6'd0 : 6'd1;
            end
            if (w_smp) begin
                r_shift   <= {r_shift[6:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // Bit i of the response lives at txdata[8*(i/8) + 7 - i%8].
            if (w_shf) begin
                r_miso   <= r_tx_idx[5] ? MISO_IDLE : r_tx[{r_tx_idx[4:3], ~r_tx_idx[2:0]}];
                r_tx_idx <= r_tx_idx[5] ? r_tx_idx : r_tx_idx + 6'd1;
            end
            if (r_pend) begin
                r_rx_byte <= r_shift;
                r_rx_idx  <= r_cnt;
                r_cnt     <= r_cnt == 3'd7 ? r_cnt : r_cnt + 3'd1;
                if (!r_cnt[2]) r_shadow[{r_cnt[1:0], 3'b000} +: 8] <= r_shift;
            end
            if (w_fin) begin
                r_readdata  <= r_shadow;
                r_byte_cnt  <= r_cnt;
                r_frame_err <= (r_bit_cnt != 3'd0) || (r_cnt > 3'd4);
                r_miso_oe   <= 1'b0;
                r_miso      <= MISO_IDLE;
            end
        end
    end

    assign bus.rx_byte       = r_rx_byte;
    assign bus.rx_byte_valid = r_rx_valid;
    assign bus.rx_byte_idx   = r_rx_idx;
    assign bus.readdata      = r_readdata;
    assign bus.byte_cnt      = r_byte_cnt;
    assign bus.frame_done    = r_frame_done;
    assign bus.frame_err     = r_frame_err;
    assign bus.busy          = r_state == SHIFT;
    assign bus.miso          = r_miso;
    assign bus.miso_oe       = r_miso_oe;
endmodule

// File: tb/tb_spi_slave_bytes.sv
// tb_spi_slave_bytes: directed SPI-master stimulus against spi_slave_bytes with inline checks.
module tb_spi_slave_bytes;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   last_valid_cyc = 0;
    int   last_samp_cyc = 0;
    logic [10:0] rx_q[$];

    spi_slave_bytes_if bus();

    spi_slave_bytes #(.SYNC_STAGES(2), .MISO_IDLE(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_byte_valid) begin
            rx_q.push_back({bus.rx_byte_idx, bus.rx_byte});
            last_valid_cyc = cyc;
        end
        if (bus.frame_done) n_done = n_done + 1;
    end

    task automatic set_mode(input logic [1:0] m, input logic [31:0] tx);
        bus.mode   = m;
        bus.txdata = tx;
        bus.sck    = m[1];
        bus.cs     = 1'b1;
        bus.mosi   = 1'b0;
        #HALF;
    endtask

    task automatic shift_bits(input logic [1:0] m, input int nbits, input logic [63:0] wd,
                              output logic [63:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            int k;
            k = (i / 8) * 8 + 7 - (i % 8);
            if (!m[0]) begin
                bus.mosi = wd[k];
                #HALF;
                bus.sck = ~m[1];
                rd[k] = bus.miso;
                last_samp_cyc = cyc;
                #HALF;
                bus.sck = m[1];
            end else begin
                #HALF;
                bus.sck = ~m[1];
                bus.mosi = wd[k];
                #HALF;
                bus.sck = m[1];
                rd[k] = bus.miso;
                last_samp_cyc = cyc;
            end
        end
        #HALF;
    endtask

    task automatic frame(input logic [1:0] m, input logic [31:0] tx, input int nbits,
                         input logic [63:0] wd, output logic [63:0] rd);
        set_mode(m, tx);
        rx_q.delete();
        bus.cs = 1'b0;
        #HALF;
        bus.mode   = ~m;
        bus.txdata = ~tx;
        shift_bits(m, nbits, wd, rd);
        bus.cs = 1'b1;
        #150;
    endtask

    task automatic test_reset();
        bus.mode = 2'd0; bus.txdata = '0; bus.cs = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.rx_byte_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", bus.rx_byte_valid); else n_pass++;
        n_chk++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", bus.frame_done); else n_pass++;
        n_chk++; if (bus.readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", bus.readdata); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd0) $display("FAIL reset_byte_cnt got %0d want 0", bus.byte_cnt); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b want 0", bus.miso_oe); else n_pass++;
        n_chk++; if (bus.miso !== 1'b1) $display("FAIL reset_miso got %b want 1", bus.miso); else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [63:0] rd;
        logic [43:0] got;
        int d;
        d = n_done;
        frame(2'd0, 32'h12345678, 32, 64'hA5C30F81, rd);
        got = (rx_q.size() == 4) ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : '0;
        n_chk++; if (got !== {3'd0, 8'h81, 3'd1, 8'h0F, 3'd2, 8'hC3, 3'd3, 8'hA5}) $display("FAIL m0_rx_seq got %h want %h", got, {3'd0, 8'h81, 3'd1, 8'h0F, 3'd2, 8'hC3, 3'd3, 8'hA5}); else n_pass++;
        n_chk++; if (bus.readdata !== 32'hA5C30F81) $display("FAIL m0_readdata got %h want a5c30f81", bus.readdata); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd4) $display("FAIL m0_byte_cnt got %0d want 4", bus.byte_cnt); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL m0_frame_err got %b want 0", bus.frame_err); else n_pass++;
        n_chk++; if (rd[31:0] !== 32'h12345678) $display("FAIL m0_master_read got %h want 12345678", rd[31:0]); else n_pass++;
        n_chk++; if (n_done - d !== 1) $display("FAIL m0_done_count got %0d want 1", n_done - d); else n_pass++;
        n_chk++; if (last_valid_cyc - last_samp_cyc !== 4) $display("FAIL m0_rx_latency got %0d want 4", last_valid_cyc - last_samp_cyc); else n_pass++;
        n_chk++; if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b1) $display("FAIL m0_idle_pins got oe=%b miso=%b want oe=0 miso=1", bus.miso_oe, bus.miso); else n_pass++;
    endtask

    task automatic test_modes();
        logic [63:0] rd;
        for (int m = 1; m < 4; m++) begin
            frame(m[1:0], 32'h0000BEEF, 16, 64'h3C96, rd);
            n_chk++; if (bus.readdata !== 32'h00003C96) $display("FAIL mode%0d_readdata got %h want 00003c96", m, bus.readdata); else n_pass++;
            n_chk++; if (bus.byte_cnt !== 3'd2) $display("FAIL mode%0d_byte_cnt got %0d want 2", m, bus.byte_cnt); else n_pass++;
            n_chk++; if (rd[15:0] !== 16'hBEEF) $display("FAIL mode%0d_master_read got %h want beef", m, rd[15:0]); else n_pass++;
            n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL mode%0d_frame_err got %b want 0", m, bus.frame_err); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd0, rd1;
        int d;
        d = n_done;
        set_mode(2'd0, 32'h0000A55A);
        rx_q.delete();
        bus.cs = 1'b0;
        #HALF;
        shift_bits(2'd0, 8, 64'h3A, rd0);
        #(2 * HALF);
        n_chk++; if (n_done - d !== 0) $display("FAIL b2b_no_early_done got %0d want 0", n_done - d); else n_pass++;
        shift_bits(2'd0, 8, 64'hC5, rd1);
        bus.cs = 1'b1;
        #150;
        n_chk++; if (n_done - d !== 1) $display("FAIL b2b_done_count got %0d want 1", n_done - d); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd2) $display("FAIL b2b_byte_cnt got %0d want 2", bus.byte_cnt); else n_pass++;
        n_chk++; if (bus.readdata !== 32'h0000C53A) $display("FAIL b2b_readdata got %h want 0000c53a", bus.readdata); else n_pass++;
        n_chk++; if (rx_q.size() !== 2 || rx_q[0][10:8] !== 3'd0 || rx_q[1][10:8] !== 3'd1) $display("FAIL b2b_idx got n=%0d want n=2 idx 0,1", rx_q.size()); else n_pass++;
        n_chk++; if ({rd1[7:0], rd0[7:0]} !== 16'hA55A) $display("FAIL b2b_master_read got %h want a55a", {rd1[7:0], rd0[7:0]}); else n_pass++;
    endtask

    task automatic test_partial();
        logic [63:0] rd;
        frame(2'd0, 32'h0, 12, 64'hA0E7, rd);
        n_chk++; if (bus.byte_cnt !== 3'd1) $display("FAIL partial_byte_cnt got %0d want 1", bus.byte_cnt); else n_pass++;
        n_chk++; if (bus.readdata !== 32'h000000E7) $display("FAIL partial_readdata got %h want 000000e7", bus.readdata); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL partial_frame_err got %b want 1", bus.frame_err); else n_pass++;
        n_chk++; if (rx_q.size() !== 1) $display("FAIL partial_rx_count got %0d want 1", rx_q.size()); else n_pass++;
    endtask

    task automatic test_overlong();
        logic [63:0] rd;
        frame(2'd0, 32'hCAFEF00D, 40, 64'h5544332211, rd);
        n_chk++; if (bus.readdata !== 32'h44332211) $display("FAIL long_readdata got %h want 44332211", bus.readdata); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd5) $display("FAIL long_byte_cnt got %0d want 5", bus.byte_cnt); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL long_frame_err got %b want 1", bus.frame_err); else n_pass++;
        n_chk++; if (rx_q.size() !== 5) $display("FAIL long_rx_count got %0d want 5", rx_q.size()); else n_pass++;
        n_chk++; if (rx_q.size() == 5 && rx_q[4] !== {3'd4, 8'h55}) $display("FAIL long_last_rx got %h want %h", rx_q[4], {3'd4, 8'h55}); else n_pass++;
        n_chk++; if (rd[39:32] !== 8'hFF) $display("FAIL long_idle_byte got %h want ff", rd[39:32]); else n_pass++;
        n_chk++; if (rd[31:0] !== 32'hCAFEF00D) $display("FAIL long_master_read got %h want cafef00d", rd[31:0]); else n_pass++;
    endtask

    task automatic test_zero_latency();
        int n;
        set_mode(2'd0, 32'h00000080);
        @(negedge clk);
        bus.cs = 1'b0;
        n = 0;
        while (!bus.miso_oe && n < 20) begin @(negedge clk); n++; end
        n_chk++; if (n !== 3) $display("FAIL cs_fall_latency got %0d want 3", n); else n_pass++;
        n_chk++; if (bus.miso !== 1'b1 || bus.busy !== 1'b1) $display("FAIL first_bit got miso=%b busy=%b want 1 1", bus.miso, bus.busy); else n_pass++;
        repeat (10) @(negedge clk);
        bus.cs = 1'b1;
        n = 0;
        while (!bus.frame_done && n < 20) begin @(negedge clk); n++; end
        n_chk++; if (n !== 4) $display("FAIL cs_rise_latency got %0d want 4", n); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd0 || bus.readdata !== 32'h0 || bus.frame_err !== 1'b0) $display("FAIL zero_frame got cnt=%0d data=%h err=%b want 0 0 0", bus.byte_cnt, bus.readdata, bus.frame_err); else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [63:0] rd;
        int d;
        d = n_done;
        set_mode(2'd0, 32'h0);
        bus.cs = 1'b0;
        #HALF;
        shift_bits(2'd0, 10, 64'hFFFF, rd);
        rx_q.delete();
        rst = 1'b1;
        #30;
        n_chk++; if (bus.miso !== 1'b1 || bus.miso_oe !== 1'b0 || bus.readdata !== 32'h0) $display("FAIL midrst_state got miso=%b oe=%b data=%h want 1 0 0", bus.miso, bus.miso_oe, bus.readdata); else n_pass++;
        rst = 1'b0;
        #30;
        shift_bits(2'd0, 6, 64'hFF, rd);
        bus.cs = 1'b1;
        #150;
        n_chk++; if (n_done - d !== 0) $display("FAIL midrst_no_done got %0d want 0", n_done - d); else n_pass++;
        n_chk++; if (rx_q.size() !== 0 || bus.busy !== 1'b0) $display("FAIL midrst_ignored got rx=%0d busy=%b want 0 0", rx_q.size(), bus.busy); else n_pass++;
        frame(2'd0, 32'h0, 8, 64'h5A, rd);
        n_chk++; if (bus.readdata !== 32'h0000005A) $display("FAIL midrst_next_readdata got %h want 0000005a", bus.readdata); else n_pass++;
        n_chk++; if (bus.byte_cnt !== 3'd1 || bus.frame_err !== 1'b0) $display("FAIL midrst_next_status got cnt=%0d err=%b want 1 0", bus.byte_cnt, bus.frame_err); else n_pass++;
        n_chk++; if (n_done - d !== 1) $display("FAIL midrst_done_count got %0d want 1", n_done - d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_partial();
        test_overlong();
        test_zero_latency();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
